// File: rtl/groestl_avalon_driver.sv
// Avalon-MM master feeding 64-bit message words to the Groestl hash slave and streaming the digest back out.
// Optional poll timeout is built only when GROESTL_POLL_TIMEOUT_EN is defined.
module groestl_avalon_driver #(
    parameter int unsigned HS      = 512,
    parameter int unsigned BSWAP   = 0,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] h_data,
    output logic        h_valid,
    input  logic        h_ready,
    output logic [4:0]  avm_address,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic        avm_write,
    output logic        avm_read,
    output logic        avm_chipselect,
    input  logic [31:0] avm_readdata
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RST    = 4'd1;
    localparam logic [3:0] S_WAIT_W = 4'd2;
    localparam logic [3:0] S_WLO    = 4'd3;
    localparam logic [3:0] S_WHI    = 4'd4;
    localparam logic [3:0] S_GAP    = 4'd5;
    localparam logic [3:0] S_POLL   = 4'd6;
    localparam logic [3:0] S_POLL_W = 4'd7;
    localparam logic [3:0] S_HRD    = 4'd8;
    localparam logic [3:0] S_HCAP   = 4'd9;
    localparam logic [3:0] S_HOUT   = 4'd10;
    localparam logic [3:0] S_DONE   = 4'd11;

    localparam logic [3:0] LAST_IDX = 4'(HS / 32 - 1);
    localparam logic       BS       = (BSWAP != 0);
    localparam logic [4:0] ADDR_LO  = {3'b000, BS, 1'b0};
    localparam logic [4:0] ADDR_HI  = {3'b000, BS, 1'b1};
    // The WAIT_W handshake cycle is itself bus-idle, so mid-message gaps spend
    // one cycle less in S_GAP; every high write is then followed by GAP idle cycles.
    localparam logic [3:0] GAP_LAST = 4'(GAP);
    localparam logic [3:0] GAP_MID  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    logic [3:0]  state;
    logic [63:0] word;
    logic        word_last;
    logic [3:0]  idx;
    logic [3:0]  gap_cnt;
    logic [3:0]  gap_len;
    logic        leave_gap;

    assign avm_byteenable = 4'hF;
    assign gap_len        = word_last ? GAP_LAST : GAP_MID;
    assign leave_gap      = (state == S_WHI && gap_len == 4'd0) ||
                            (state == S_GAP && gap_cnt == 4'd0);

`ifdef GROESTL_POLL_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        poll_hit;
    assign poll_hit = ({1'b0, poll_cnt} + 17'd1) >= 17'(TIMEOUT);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            word           <= '0;
            word_last      <= 1'b0;
            idx            <= '0;
            gap_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            s_ready        <= 1'b0;
            h_data         <= '0;
            h_valid        <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
`ifdef GROESTL_POLL_TIMEOUT_EN
            err            <= 1'b0;
            poll_cnt       <= '0;
`endif
        end else begin
            avm_write      <= 1'b0;
            avm_read       <= 1'b0;
            avm_chipselect <= 1'b0;
            done           <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_RST;
                        busy           <= 1'b1;
                        avm_write      <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= 5'h0F;
                        avm_writedata  <= '0;
`ifdef GROESTL_POLL_TIMEOUT_EN
                        err            <= 1'b0;
                        poll_cnt       <= '0;
`endif
                    end
                end
                S_RST: begin
                    state   <= S_WAIT_W;
                    s_ready <= 1'b1;
                end
                S_WAIT_W: begin
                    if (s_valid) begin
                        s_ready        <= 1'b0;
                        word           <= s_data;
                        word_last      <= s_last;
                        state          <= S_WLO;
                        avm_write      <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_LO;
                        avm_writedata  <= s_data[31:0];
                    end
                end
                S_WLO: begin
                    state          <= S_WHI;
                    avm_write      <= 1'b1;
                    avm_chipselect <= 1'b1;
                    avm_address    <= ADDR_HI;
                    avm_writedata  <= word[63:32];
                end
                S_WHI: begin
                    if (gap_len != 4'd0) begin
                        gap_cnt <= gap_len - 4'd1;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                end
                S_POLL: begin
                    state <= S_POLL_W;
                end
                S_POLL_W: begin
                    if (avm_readdata[0]) begin
                        idx            <= '0;
                        state          <= S_HRD;
                        avm_read       <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= 5'h10;
                    end
`ifdef GROESTL_POLL_TIMEOUT_EN
                    else if (poll_hit) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
`endif
                    else begin
`ifdef GROESTL_POLL_TIMEOUT_EN
                        if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
`endif
                        state          <= S_POLL;
                        avm_read       <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_address    <= 5'h04;
                    end
                end
                S_HRD: begin
                    state <= S_HCAP;
                end
                S_HCAP: begin
                    h_data  <= avm_readdata;
                    h_valid <= 1'b1;
                    state   <= S_HOUT;
                end
                S_HOUT: begin
                    if (h_ready) begin
                        h_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx            <= idx + 4'd1;
                            state          <= S_HRD;
                            avm_read       <= 1'b1;
                            avm_chipselect <= 1'b1;
                            avm_address    <= {1'b1, idx + 4'd1};
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (leave_gap) begin
                if (word_last) begin
                    state          <= S_POLL;
                    avm_read       <= 1'b1;
                    avm_chipselect <= 1'b1;
                    avm_address    <= 5'h04;
                end else begin
                    state   <= S_WAIT_W;
                    s_ready <= 1'b1;
                end
            end
        end
    end

endmodule
